// File: rtl/lane_latch_scheduler.sv
// lane_latch_scheduler
//   Round-robin scheduler for V latched lanes sharing one capture path. Grants one
//   requesting lane, holds its latch enable high for HOLD cycles, keeps all enables
//   low for GUARD cycles, then returns to IDLE to arbitrate again from the lane after
//   the last grant.
//
// Ports:
//   i_clk   - clock, rising edge
//   i_rst   - synchronous active-high reset (overrides i_pause)
//   i_req   - per-lane request, level-sensitive
//   i_pause - freezes state, counter, pointer and enables
//   o_en    - per-lane latch enable, one-hot or zero
//   o_sel   - index of the most recently granted lane
//   o_busy  - high while not IDLE
//   o_done  - one-cycle pulse in the cycle after a window closes
module lane_latch_scheduler #(
    parameter int unsigned V     = 8,
    parameter int unsigned HOLD  = 2,
    parameter int unsigned GUARD = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [V-1:0]         i_req,
    input  logic                 i_pause,
    output logic [V-1:0]         o_en,
    output logic [$clog2(V)-1:0] o_sel,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int unsigned SelW  = $clog2(V);
    // One spare bit so pointer + offset cannot overflow before the modulo wrap.
    localparam int unsigned LaneW = SelW + 1;

    localparam logic [3:0]      HoldInit  = 4'(HOLD - 1);
    localparam logic [3:0]      GuardInit = (GUARD > 0) ? 4'(GUARD - 1) : 4'd0;
    localparam logic [SelW-1:0] LastLane  = SelW'(V - 1);

    typedef enum logic [1:0] {
        StIdle,
        StOpen,
        StGuard
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [SelW-1:0] ptr_q, ptr_d;
    logic [SelW-1:0] sel_q, sel_d;
    logic [V-1:0]    en_q, en_d;
    logic            done_q, done_d;

    logic            grant_vld;
    logic [SelW-1:0] grant_idx;
    logic [LaneW-1:0] lane;

    // Circular priority search: first set request at or above the pointer, wrapping.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        lane      = '0;
        for (int unsigned i = 0; i < V; i++) begin
            lane = {1'b0, ptr_q} + LaneW'(i);
            if (lane >= LaneW'(V)) begin
                lane = lane - LaneW'(V);
            end
            if (!grant_vld && i_req[lane[SelW-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = lane[SelW-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        en_d    = en_q;
        done_d  = 1'b0;
        if (!i_pause) begin
            unique case (state_q)
                StIdle: begin
                    if (grant_vld) begin
                        state_d         = StOpen;
                        cnt_d           = HoldInit;
                        sel_d           = grant_idx;
                        en_d            = '0;
                        en_d[grant_idx] = 1'b1;
                    end
                end
                StOpen: begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        en_d   = '0;
                        ptr_d  = (sel_q == LastLane) ? '0 : sel_q + SelW'(1);
                        done_d = 1'b1;
                        if (GUARD > 0) begin
                            state_d = StGuard;
                            cnt_d   = GuardInit;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                StGuard: begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ptr_q   <= '0;
            sel_q   <= '0;
            en_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            done_q  <= done_d;
        end
    end

    assign o_en   = en_q;
    assign o_sel  = sel_q;
    assign o_busy = (state_q != StIdle);
    assign o_done = done_q;

endmodule

// File: tb/tb_lane_latch_scheduler.sv
// Bench for lane_latch_scheduler: three instances (8/2/1, 8/2/0, 5/3/2) share the
// stimulus; each is compared every cycle against a behavioural window model, with
// directed scenarios followed by random traffic.
module tb_lane_latch_scheduler;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [7:0] req;
    logic       pause;

    logic [7:0] en_a, en_b;
    logic [4:0] en_c;
    logic [2:0] sel_a, sel_b, sel_c;
    logic       busy_a, busy_b, busy_c;
    logic       done_a, done_b, done_c;

    int n_checks = 0;
    int n_errors = 0;

    always #5 i_clk = ~i_clk;

    lane_latch_scheduler #(.V(8), .HOLD(2), .GUARD(1)) dut_a (
        .i_clk(i_clk), .i_rst(i_rst), .i_req(req), .i_pause(pause),
        .o_en(en_a), .o_sel(sel_a), .o_busy(busy_a), .o_done(done_a)
    );

    lane_latch_scheduler #(.V(8), .HOLD(2), .GUARD(0)) dut_b (
        .i_clk(i_clk), .i_rst(i_rst), .i_req(req), .i_pause(pause),
        .o_en(en_b), .o_sel(sel_b), .o_busy(busy_b), .o_done(done_b)
    );

    lane_latch_scheduler #(.V(5), .HOLD(3), .GUARD(2)) dut_c (
        .i_clk(i_clk), .i_rst(i_rst), .i_req(req[4:0]), .i_pause(pause),
        .o_en(en_c), .o_sel(sel_c), .o_busy(busy_c), .o_done(done_c)
    );

    // Window model: phase 0 idle, 1 enable window, 2 guard; left = cycles still to run.
    typedef struct {
        int          phase;
        int          left;
        int          ptr;
        int          sel;
        logic [31:0] en;
        bit          done;
    } mdl_t;

    mdl_t ma, mb, mc;

    function automatic mdl_t mdl_next(mdl_t m, int v, int hold, int guard,
                                      logic [31:0] rq, bit p, bit r);
        mdl_t n = m;
        if (r) begin
            n.phase = 0; n.left = 0; n.ptr = 0; n.sel = 0; n.en = '0; n.done = 0;
            return n;
        end
        n.done = 0;
        if (p) return n;
        case (m.phase)
            0: begin
                for (int k = 0; k < v; k++) begin
                    int l;
                    l = (m.ptr + k) % v;
                    if (rq[l]) begin
                        n.phase = 1;
                        n.left  = hold;
                        n.sel   = l;
                        n.en    = 32'd1 << l;
                        break;
                    end
                end
            end
            1: begin
                n.left = m.left - 1;
                if (n.left == 0) begin
                    n.en    = '0;
                    n.ptr   = (m.sel + 1) % v;
                    n.done  = 1;
                    n.phase = (guard > 0) ? 2 : 0;
                    n.left  = guard;
                end
            end
            default: begin
                n.left = m.left - 1;
                if (n.left == 0) n.phase = 0;
            end
        endcase
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive at negedge, advance models at posedge, compare at the following negedge.
    task automatic step(input logic [7:0] rq, input bit p, input bit r);
        req   = rq;
        pause = p;
        i_rst = r;
        @(posedge i_clk);
        ma = mdl_next(ma, 8, 2, 1, {24'd0, rq}, p, r);
        mb = mdl_next(mb, 8, 2, 0, {24'd0, rq}, p, r);
        mc = mdl_next(mc, 5, 3, 2, {27'd0, rq[4:0]}, p, r);
        @(negedge i_clk);
        check("a_en", {24'd0, en_a}, ma.en);
        check("a_sel", {29'd0, sel_a}, ma.sel);
        check("a_busy", {31'd0, busy_a}, {31'd0, ma.phase != 0});
        check("a_done", {31'd0, done_a}, {31'd0, ma.done});
        check("a_onehot", {31'd0, $countones(en_a) <= 1}, 32'd1);
        check("b_en", {24'd0, en_b}, mb.en);
        check("b_sel", {29'd0, sel_b}, mb.sel);
        check("b_busy", {31'd0, busy_b}, {31'd0, mb.phase != 0});
        check("b_done", {31'd0, done_b}, {31'd0, mb.done});
        check("c_en", {27'd0, en_c}, mc.en);
        check("c_sel", {29'd0, sel_c}, mc.sel);
        check("c_busy", {31'd0, busy_c}, {31'd0, mc.phase != 0});
        check("c_done", {31'd0, done_c}, {31'd0, mc.done});
        check("c_onehot", {31'd0, $countones(en_c) <= 1}, 32'd1);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] gz_seq [6];
        int rises, dones, en_cnt;
        logic [7:0] prev_en;
        ma = '{default: 0};
        mb = '{default: 0};
        mc = '{default: 0};
        gz_seq = '{8'h01, 8'h01, 8'h00, 8'h02, 8'h02, 8'h00};

        // Reset values with all requests high, then first grant is lane 0.
        for (int i = 0; i < 3; i++) begin
            step(8'hFF, 1'b0, 1'b1);
            check("rst_en", {24'd0, en_a}, 32'h0);
            check("rst_busy", {31'd0, busy_a}, 32'h0);
        end
        step(8'hFF, 1'b0, 1'b0);
        check("rst_first_grant", {24'd0, en_a}, 32'h01);

        // Single request.
        step(8'h00, 1'b0, 1'b1);
        step(8'h08, 1'b0, 1'b0);
        check("single_en1", {24'd0, en_a}, 32'h08);
        check("single_sel", {29'd0, sel_a}, 32'd3);
        step(8'h00, 1'b0, 1'b0);
        check("single_en2", {24'd0, en_a}, 32'h08);
        step(8'h00, 1'b0, 1'b0);
        check("single_done", {31'd0, done_a}, 32'd1);
        check("single_en_off", {24'd0, en_a}, 32'h0);
        step(8'hFF, 1'b0, 1'b0);
        check("single_idle", {31'd0, busy_a}, 32'd0);
        step(8'hFF, 1'b0, 1'b0);
        check("single_ptr4", {29'd0, sel_a}, 32'd4);

        // Full rotation.
        step(8'h00, 1'b0, 1'b1);
        rises = 0; dones = 0; prev_en = '0;
        for (int i = 0; i < 36; i++) begin
            step(8'hFF, 1'b0, 1'b0);
            if (en_a != 8'h00 && prev_en == 8'h00) begin
                check("rot_order", {29'd0, sel_a}, rises % 8);
                check("rot_phase", i % 4, 0);
                rises++;
            end
            if (done_a) dones++;
            prev_en = en_a;
        end
        check("rot_rises", rises, 9);
        check("rot_dones", dones, 9);

        // Wrap and skip.
        step(8'h00, 1'b0, 1'b1);
        step(8'h80, 1'b0, 1'b0);
        check("wrap_first", {29'd0, sel_a}, 32'd7);
        idle_steps(3);
        step(8'h81, 1'b0, 1'b0);
        check("wrap_lane0", {29'd0, sel_a}, 32'd0);
        idle_steps(3);
        step(8'h81, 1'b0, 1'b0);
        check("wrap_lane7", {29'd0, sel_a}, 32'd7);
        step(8'h00, 1'b0, 1'b1);
        step(8'h20, 1'b0, 1'b0);
        idle_steps(3);
        step(8'h20, 1'b0, 1'b0);
        check("skip_lane5", {24'd0, en_a}, 32'h20);
        idle_steps(3);
        step(8'hFF, 1'b0, 1'b0);
        check("skip_ptr6", {29'd0, sel_a}, 32'd6);

        // Pause mid-window, then pause in IDLE.
        step(8'h00, 1'b0, 1'b1);
        en_cnt = 0;
        step(8'h01, 1'b0, 1'b0);
        if (en_a != 0) en_cnt++;
        step(8'h00, 1'b0, 1'b0);
        if (en_a != 0) en_cnt++;
        for (int i = 0; i < 3; i++) begin
            step(8'h00, 1'b1, 1'b0);
            if (en_a != 0) en_cnt++;
            check("pause_no_done", {31'd0, done_a}, 32'd0);
        end
        step(8'h00, 1'b0, 1'b0);
        check("pause_en_cycles", en_cnt, 5);
        check("pause_done", {31'd0, done_a}, 32'd1);
        idle_steps(2);
        step(8'h01, 1'b1, 1'b0);
        check("pause_idle_nogrant", {24'd0, en_a}, 32'h0);

        // GUARD=0 sequence on instance b.
        step(8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(8'h03, 1'b0, 1'b0);
            check("g0_seq", {24'd0, en_b}, {24'd0, gz_seq[i]});
        end

        // Reset mid-window.
        step(8'h00, 1'b0, 1'b1);
        step(8'h03, 1'b0, 1'b0);
        step(8'h03, 1'b0, 1'b0);
        step(8'h03, 1'b0, 1'b1);
        check("midrst_en", {24'd0, en_a}, 32'h0);
        check("midrst_done", {31'd0, done_a}, 32'd0);
        step(8'h03, 1'b0, 1'b0);
        check("midrst_regrant", {24'd0, en_a}, 32'h01);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            logic [7:0] rq;
            rq = 8'($urandom);
            if ($urandom_range(0, 3) == 0) rq = rq & 8'($urandom);
            step(rq, $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
